// File: rtl/skew_feeder_pkg.sv
// Shared types and index helpers for the skew feeder: FSM state, beat count
// and bit-offset arithmetic for the flattened matrix and lane vectors.
package skew_feeder_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Diagonal beats needed to push a rows x cols matrix through the wavefront.
   function automatic int beats(input int rows, input int cols);
      return rows + cols - 1;
   endfunction

   // LSB of row r inside the flattened matrix.
   function automatic int row_lsb(input int r, input int cols, input int width);
      return r * cols * width;
   endfunction

   // LSB of element idx inside a packed vector of width-bit elements.
   function automatic int lane_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/skew_feeder_if.sv
// Matrix-in / diagonal-beat-out bus of the skew feeder. The slave modport is
// the feeder side; the master modport is the producer/consumer side.
interface skew_feeder_if #(
   parameter int WIDTH = 4,
   parameter int ROWS  = 3,
   parameter int COLS  = 3
);
   import skew_feeder_pkg::*;

   localparam int BEATS = beats(ROWS, COLS);
   localparam int IDXW  = $clog2(BEATS + 1);

   logic                        in_valid;
   logic                        in_ready;
   logic [ROWS*COLS*WIDTH-1:0]  in_mat;
   logic                        in_rvs;
   logic                        out_valid;
   logic                        out_ready;
   logic [ROWS*WIDTH-1:0]       out_vec;
   logic [IDXW-1:0]             out_idx;
   logic                        out_last;
   logic                        busy;

   modport slave (
      input  in_valid, in_mat, in_rvs, out_ready,
      output in_ready, out_valid, out_vec, out_idx, out_last, busy
   );

   modport master (
      output in_valid, in_mat, in_rvs, out_ready,
      input  in_ready, out_valid, out_vec, out_idx, out_last, busy
   );

endinterface

// File: rtl/skew_feeder_lane_mux.sv
// One output lane: picks the row element that falls on the current diagonal
// beat for this lane, in forward or reversed column order, else drives 0.
module skew_feeder_lane_mux
   import skew_feeder_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int COLS  = 3,
   parameter int LANE  = 0,
   parameter int IDXW  = 3
) (
   input  logic [COLS*WIDTH-1:0] i_row,
   input  logic [IDXW-1:0]       i_beat,
   input  logic                  i_rvs,
   output logic [WIDTH-1:0]      o_lane
);

   // Column c appears at window offset j = c (or COLS-1-c reversed), i.e. on beat LANE+j.
   always_comb begin
      o_lane = '0;
      for (int c = 0; c < COLS; c++) begin
         if (int'(i_beat) == LANE + (i_rvs ? (COLS - 1 - c) : c))
            o_lane = i_row[lane_lsb(c, WIDTH) +: WIDTH];
      end
   end

endmodule

// File: rtl/skew_feeder.sv
// Matrix skew feeder: captures a ROWS x COLS matrix and streams ROWS+COLS-1
// staggered diagonal beats. Define SKEW_FEEDER_DBLBUF_EN for a shadow buffer.
module skew_feeder
   import skew_feeder_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int ROWS  = 3,
   parameter int COLS  = 3
) (
   input  logic         i_clk,
   input  logic         i_rst,
   skew_feeder_if.slave bus
);

   localparam int BEATS = beats(ROWS, COLS);
   localparam int IDXW  = $clog2(BEATS + 1);
   localparam int MATW  = ROWS * COLS * WIDTH;
   localparam logic [IDXW-1:0] LAST_BEAT = IDXW'(BEATS - 1);

   state_t                r_state;
   logic [IDXW-1:0]       r_beat;
   logic [MATW-1:0]       r_act_mat;
   logic                  r_act_rvs;

   logic                  w_streaming;
   logic                  w_last;
   logic                  w_out_hs;
   logic [ROWS*WIDTH-1:0] w_vec;

   assign w_streaming = (r_state == STREAM);
   assign w_last      = (r_beat == LAST_BEAT);
   assign w_out_hs    = w_streaming && bus.out_ready;

`ifdef SKEW_FEEDER_DBLBUF_EN
   logic [MATW-1:0] r_shd_mat;
   logic            r_shd_rvs;
   logic            r_shd_valid;
   logic            w_in_hs;

   assign bus.in_ready = !w_streaming || !r_shd_valid;
   assign w_in_hs      = bus.in_valid && bus.in_ready;
`else
   assign bus.in_ready = !w_streaming;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_beat    <= '0;
         r_act_mat <= '0;
         r_act_rvs <= 1'b0;
`ifdef SKEW_FEEDER_DBLBUF_EN
         r_shd_mat   <= '0;
         r_shd_rvs   <= 1'b0;
         r_shd_valid <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_act_mat <= bus.in_mat;
                  r_act_rvs <= bus.in_rvs;
                  r_beat    <= '0;
                  r_state   <= STREAM;
               end
            end
            STREAM: begin
`ifdef SKEW_FEEDER_DBLBUF_EN
               if (w_out_hs && w_last) begin
                  r_beat <= '0;
                  // Prefer the queued shadow; otherwise an arriving matrix skips the shadow.
                  if (r_shd_valid) begin
                     r_act_mat   <= r_shd_mat;
                     r_act_rvs   <= r_shd_rvs;
                     r_shd_valid <= 1'b0;
                  end else if (bus.in_valid) begin
                     r_act_mat <= bus.in_mat;
                     r_act_rvs <= bus.in_rvs;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  if (w_out_hs)
                     r_beat <= r_beat + IDXW'(1);
                  if (w_in_hs) begin
                     r_shd_mat   <= bus.in_mat;
                     r_shd_rvs   <= bus.in_rvs;
                     r_shd_valid <= 1'b1;
                  end
               end
`else
               if (w_out_hs) begin
                  if (w_last) begin
                     r_beat  <= '0;
                     r_state <= IDLE;
                  end else begin
                     r_beat <= r_beat + IDXW'(1);
                  end
               end
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
      skew_feeder_lane_mux #(
         .WIDTH (WIDTH),
         .COLS  (COLS),
         .LANE  (gi),
         .IDXW  (IDXW)
      ) u_lane (
         .i_row  (r_act_mat[row_lsb(gi, COLS, WIDTH) +: COLS*WIDTH]),
         .i_beat (r_beat),
         .i_rvs  (r_act_rvs),
         .o_lane (w_vec[lane_lsb(gi, WIDTH) +: WIDTH])
      );
   end

   assign bus.out_valid = w_streaming;
   assign bus.out_vec   = w_streaming ? w_vec : '0;
   assign bus.out_idx   = w_streaming ? r_beat : '0;
   assign bus.out_last  = w_streaming && w_last;
   assign bus.busy      = w_streaming;

endmodule

// File: tb/tb_skew_feeder.sv
// Directed and randomized bench for skew_feeder on a 3x3 and a 2x4 instance,
// checked against a diagonal-beat reference computed from the matrix directly.
module tb_skew_feeder;

   localparam logic [63:0] MAT_A = 64'h4_9856_7321;
   localparam logic [63:0] MAT_B = 64'h8765_4321;
   localparam int B0 = 5;
`ifdef SKEW_FEEDER_DBLBUF_EN
   localparam int EXP_GAPS = 0;
`else
   localparam int EXP_GAPS = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   skew_feeder_if #(.WIDTH(4), .ROWS(3), .COLS(3)) if0();
   skew_feeder_if #(.WIDTH(4), .ROWS(2), .COLS(4)) if1();

   skew_feeder #(.WIDTH(4), .ROWS(3), .COLS(3)) dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));
   skew_feeder #(.WIDTH(4), .ROWS(2), .COLS(4)) dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));

   // Beat t, lane r carries M[r][j] (or M[r][cols-1-j] reversed) with j = t - r.
   function automatic logic [63:0] model(input int rows, input int cols, input logic [63:0] mat,
                                         input logic rvs, input int t);
      logic [63:0] res;
      res = '0;
      for (int r = 0; r < rows; r++) begin
         int j;
         j = t - r;
         if (j >= 0 && j < cols) begin
            int col;
            col = rvs ? cols - 1 - j : j;
            res = res | (((mat >> ((r * cols + col) * 4)) & 64'hF) << (r * 4));
         end
      end
      return res;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send0(input logic [63:0] mat, input logic rvs);
      check("in_ready_idle", {63'd0, if0.in_ready}, 64'd1);
      if0.in_valid = 1'b1;
      if0.in_mat   = mat[35:0];
      if0.in_rvs   = rvs;
      @(negedge clk);
      if0.in_valid = 1'b0;
   endtask

   // Consume all beats of the active matrix, optionally stalling at hold_beat
   // for hold_n cycles and otherwise stalling with probability bp_pct percent.
   task automatic drain0(input logic [63:0] mat, input logic rvs, input int hold_beat,
                         input int hold_n, input int bp_pct);
      int t;
      int held;
      int cyc;
      t = 0;
      held = 0;
      cyc = 0;
      while (t < B0 && cyc < 200) begin
         check("beat_valid", {63'd0, if0.out_valid}, 64'd1);
         check("beat_vec", {52'd0, if0.out_vec}, model(3, 3, mat, rvs, t));
         check("beat_idx", {61'd0, if0.out_idx}, 64'(t));
         check("beat_last", {63'd0, if0.out_last}, {63'd0, (t == B0 - 1)});
         if (t == hold_beat && held < hold_n) begin
            if0.out_ready = 1'b0;
            held++;
         end else begin
            if0.out_ready = ($urandom_range(99) >= bp_pct);
         end
         if (if0.out_ready) t++;
         @(negedge clk);
         cyc++;
      end
      if0.out_ready = 1'b1;
      check("drain_done", 64'(t), 64'(B0));
      check("idle_valid", {63'd0, if0.out_valid}, 64'd0);
      check("idle_ready", {63'd0, if0.in_ready}, 64'd1);
      check("idle_busy", {63'd0, if0.busy}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] exp5 [5];
      logic [63:0] q_exp [$];
      logic [63:0] rmat;
      logic [63:0] cmat;
      logic        rrvs;
      int sent, nvalid, gaps;

      rst = 1'b1;
      if0.in_valid = 1'b0; if0.in_mat = '0; if0.in_rvs = 1'b0; if0.out_ready = 1'b1;
      if1.in_valid = 1'b0; if1.in_mat = '0; if1.in_rvs = 1'b0; if1.out_ready = 1'b1;
      #1;
      check("rst_in_ready", {63'd0, if0.in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, if0.out_valid}, 64'd0);
      check("rst_out_vec", {52'd0, if0.out_vec}, 64'd0);
      check("rst_out_idx", {61'd0, if0.out_idx}, 64'd0);
      check("rst_out_last", {63'd0, if0.out_last}, 64'd0);
      check("rst_busy", {63'd0, if0.busy}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Basic forward feed, then reverse feed
      send0(MAT_A, 1'b0);
      check("basic_first", {52'd0, if0.out_vec}, 64'h001);
      drain0(MAT_A, 1'b0, -1, 0, 0);
      send0(MAT_A, 1'b1);
      check("rvs_first", {52'd0, if0.out_vec}, 64'h003);
      drain0(MAT_A, 1'b1, -1, 0, 0);

      // Back-pressure: three stall cycles at beat 2
      send0(MAT_A, 1'b0);
      drain0(MAT_A, 1'b0, 2, 3, 0);

      // Reset in the middle of a stream
      send0(MAT_A, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("pre_rst_vec", {52'd0, if0.out_vec}, model(3, 3, MAT_A, 1'b0, i));
         @(negedge clk);
      end
      check("pre_rst_idx", {61'd0, if0.out_idx}, 64'd3);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_valid", {63'd0, if0.out_valid}, 64'd0);
      check("mid_rst_ready", {63'd0, if0.in_ready}, 64'd1);
      check("mid_rst_vec", {52'd0, if0.out_vec}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_valid", {63'd0, if0.out_valid}, 64'd0);
      send0(MAT_A, 1'b0);
      check("restart_vec", {52'd0, if0.out_vec}, 64'h001);
      drain0(MAT_A, 1'b0, -1, 0, 0);

      // Non-square 2x4 instance against the literal beat sequence
      exp5 = '{64'h01, 64'h52, 64'h63, 64'h74, 64'h80};
      if1.in_valid = 1'b1; if1.in_mat = MAT_B[31:0]; if1.in_rvs = 1'b0;
      @(negedge clk);
      if1.in_valid = 1'b0;
      for (int t = 0; t < 5; t++) begin
         check("shape_vec", {56'd0, if1.out_vec}, exp5[t]);
         check("shape_idx", {61'd0, if1.out_idx}, 64'(t));
         @(negedge clk);
      end
      check("shape_idle", {63'd0, if1.out_valid}, 64'd0);

      // Random matrices on the 2x4 instance
      for (int k = 0; k < 4; k++) begin
         rmat = {32'd0, $urandom};
         rrvs = 1'($urandom_range(1));
         if1.in_valid = 1'b1; if1.in_mat = rmat[31:0]; if1.in_rvs = rrvs;
         @(negedge clk);
         if1.in_valid = 1'b0;
         for (int t = 0; t < 5; t++) begin
            check("rnd_shape_vec", {56'd0, if1.out_vec}, model(2, 4, rmat, rrvs, t));
            @(negedge clk);
         end
      end

      // Random matrices with random back-pressure on the 3x3 instance
      for (int k = 0; k < 8; k++) begin
         rmat = {28'd0, 4'($urandom), $urandom};
         rrvs = 1'($urandom_range(1));
         send0(rmat, rrvs);
         drain0(rmat, rrvs, -1, 0, 35);
      end

      // Two matrices offered back-to-back
      cmat = {28'd0, 4'($urandom), $urandom};
      for (int t = 0; t < B0; t++) q_exp.push_back(model(3, 3, MAT_A, 1'b0, t));
      for (int t = 0; t < B0; t++) q_exp.push_back(model(3, 3, cmat, 1'b1, t));
      sent = 0; nvalid = 0; gaps = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (if0.out_valid) begin
            if (q_exp.size() > 0)
               check("b2b_vec", {52'd0, if0.out_vec}, q_exp.pop_front());
            nvalid++;
         end else if (nvalid > 0 && nvalid < 2 * B0) begin
            gaps++;
         end
         if0.in_valid = (sent < 2);
         if0.in_mat   = (sent == 0) ? MAT_A[35:0] : cmat[35:0];
         if0.in_rvs   = (sent != 0);
         if (if0.in_valid && if0.in_ready) sent++;
         @(negedge clk);
      end
      if0.in_valid = 1'b0;
      check("b2b_count", 64'(nvalid), 64'(2 * B0));
      check("b2b_gaps", 64'(gaps), 64'(EXP_GAPS));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
